// File: rtl/ofs_plat_avalon_mem_burst_split_stage.sv
`default_nettype none
// ============================================================================
// Module  : ofs_plat_avalon_mem_burst_split_stage
// Brief   : Splits long Avalon-MM source bursts into sink-legal sub-bursts.
// Revision: 1.0 - initial release
// ============================================================================

module ofs_plat_avalon_mem_burst_split_stage #(
  parameter int ADDR_WIDTH       = 27,
  parameter int DATA_WIDTH       = 512,
  parameter int SRC_BURST_WIDTH  = 7,
  parameter int SINK_BURST_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,

  input  logic [ADDR_WIDTH-1:0]       s_address,
  input  logic                        s_read,
  input  logic                        s_write,
  input  logic [SRC_BURST_WIDTH-1:0]  s_burstcount,
  input  logic [DATA_WIDTH-1:0]       s_writedata,
  input  logic [DATA_WIDTH/8-1:0]     s_byteenable,
  output logic                        s_waitrequest,
  output logic [DATA_WIDTH-1:0]       s_readdata,
  output logic                        s_readdatavalid,
  output logic [1:0]                  s_response,

  output logic [ADDR_WIDTH-1:0]       m_address,
  output logic                        m_read,
  output logic                        m_write,
  output logic [SINK_BURST_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]       m_writedata,
  output logic [DATA_WIDTH/8-1:0]     m_byteenable,
  input  logic                        m_waitrequest,
  input  logic [DATA_WIDTH-1:0]       m_readdata,
  input  logic                        m_readdatavalid,
  input  logic [1:0]                  m_response
);

  localparam int unsigned                  c_SINK_MAX_I = 2 ** (SINK_BURST_WIDTH - 1);
  localparam logic [SRC_BURST_WIDTH-1:0]   c_SINK_MAX   = c_SINK_MAX_I[SRC_BURST_WIDTH-1:0];
  localparam logic [SINK_BURST_WIDTH-1:0]  c_SINK_MAX_S = c_SINK_MAX_I[SINK_BURST_WIDTH-1:0];

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_SPLIT = 1'b1;

  function automatic logic [SINK_BURST_WIDTH-1:0] f_min_sink(input logic [SRC_BURST_WIDTH-1:0] n);
    if (n > c_SINK_MAX) return c_SINK_MAX_S;
    return n[SINK_BURST_WIDTH-1:0];
  endfunction

  logic [0:0]                  r_rd_state;
  logic [0:0]                  w_rd_state_nxt;
  logic [SRC_BURST_WIDTH-1:0]  r_rd_offset;
  logic [SRC_BURST_WIDTH-1:0]  w_rd_offset_nxt;
  logic [SRC_BURST_WIDTH-1:0]  w_rem;
  logic                        w_rd_last;
  logic                        w_m_accept;

  logic                        r_wr_in_burst;
  logic [SRC_BURST_WIDTH-1:0]  r_src_left;
  logic [SINK_BURST_WIDTH-1:0] r_sub_left;
  logic [ADDR_WIDTH-1:0]       r_wr_addr;
  logic [ADDR_WIDTH-1:0]       r_cur_addr;
  logic [SINK_BURST_WIDTH-1:0] r_cur_len;
  logic                        w_wr_new_sub;
  logic [SRC_BURST_WIDTH-1:0]  w_src_cnt;
  logic [SINK_BURST_WIDTH-1:0] w_wr_len;
  logic [ADDR_WIDTH-1:0]       w_wr_addr_cur;

  assign w_m_accept = (m_read || m_write) && !m_waitrequest;
  assign w_rem      = s_burstcount - r_rd_offset;
  assign w_rd_last  = (w_rem <= c_SINK_MAX);

  // Write sub-burst boundary: first beat of the source burst or current sub-burst exhausted
  assign w_wr_new_sub  = !r_wr_in_burst || (r_sub_left == '0);
  assign w_src_cnt     = r_wr_in_burst ? r_src_left : s_burstcount;
  assign w_wr_len      = f_min_sink(w_src_cnt);
  assign w_wr_addr_cur = r_wr_in_burst ? r_wr_addr : s_address;

  assign s_readdata      = m_readdata;
  assign s_readdatavalid = m_readdatavalid;
  assign s_response      = m_response;

  // Read FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state  <= RD_IDLE;
      r_rd_offset <= '0;
    end else begin
      r_rd_state  <= w_rd_state_nxt;
      r_rd_offset <= w_rd_offset_nxt;
    end
  end

  // Read FSM: next state
  always_comb begin
    w_rd_state_nxt  = r_rd_state;
    w_rd_offset_nxt = r_rd_offset;
    if (s_read && w_m_accept) begin
      if (w_rd_last) begin
        w_rd_state_nxt  = RD_IDLE;
        w_rd_offset_nxt = '0;
      end else begin
        w_rd_state_nxt  = RD_SPLIT;
        w_rd_offset_nxt = r_rd_offset + c_SINK_MAX;
      end
    end
  end

  // Read FSM / write path: outputs
  always_comb begin
    m_read       = s_read;
    m_write      = s_write;
    m_writedata  = s_writedata;
    m_byteenable = s_byteenable;
    if (s_write) begin
      m_address     = w_wr_new_sub ? w_wr_addr_cur : r_cur_addr;
      m_burstcount  = w_wr_new_sub ? w_wr_len : r_cur_len;
      s_waitrequest = m_waitrequest;
    end else begin
      m_address     = s_address + ADDR_WIDTH'(r_rd_offset);
      m_burstcount  = w_rd_last ? w_rem[SINK_BURST_WIDTH-1:0] : c_SINK_MAX_S;
      s_waitrequest = w_rd_last ? m_waitrequest : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_in_burst <= 1'b0;
      r_src_left    <= '0;
      r_sub_left    <= '0;
      r_wr_addr     <= '0;
      r_cur_addr    <= '0;
      r_cur_len     <= '0;
    end else if (s_write && w_m_accept) begin
      r_src_left    <= w_src_cnt - 1'b1;
      r_wr_in_burst <= (w_src_cnt != SRC_BURST_WIDTH'(1));
      if (w_wr_new_sub) begin
        r_sub_left <= w_wr_len - 1'b1;
        r_wr_addr  <= w_wr_addr_cur + ADDR_WIDTH'(w_wr_len);
        r_cur_addr <= w_wr_addr_cur;
        r_cur_len  <= w_wr_len;
      end else begin
        r_sub_left <= r_sub_left - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(s_read && s_write));
  a_rd_in_wr_burst: assert property (@(posedge clk) disable iff (!reset_n)
    !(s_read && r_wr_in_burst));
  a_burstcount_nz: assert property (@(posedge clk) disable iff (!reset_n)
    (s_read || (s_write && !r_wr_in_burst)) |-> (s_burstcount != '0));
  a_rd_cmd_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (s_read && s_waitrequest) |=> (s_read && $stable(s_address) && $stable(s_burstcount)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ofs_plat_avalon_mem_burst_split_stage.sv
`default_nettype none
// Scoreboard bench for the burst split stage: stimulus pushes expected sink commands, a monitor pops them.

module tb_ofs_plat_avalon_mem_burst_split_stage;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [26:0]  s_address = '0;
  logic         s_read = 1'b0;
  logic         s_write = 1'b0;
  logic [6:0]   s_burstcount = 7'd1;
  logic [511:0] s_writedata = '0;
  logic [63:0]  s_byteenable = '0;
  wire          s_waitrequest;
  wire  [511:0] s_readdata;
  wire          s_readdatavalid;
  wire  [1:0]   s_response;
  wire  [26:0]  m_address;
  wire          m_read;
  wire          m_write;
  wire  [3:0]   m_burstcount;
  wire  [511:0] m_writedata;
  wire  [63:0]  m_byteenable;
  logic         m_waitrequest = 1'b0;
  logic [511:0] m_readdata = '0;
  logic         m_readdatavalid = 1'b0;
  logic [1:0]   m_response = '0;

  wire          s8_waitrequest;
  wire  [511:0] s8_readdata;
  wire          s8_readdatavalid;
  wire  [1:0]   s8_response;
  wire  [7:0]   m8_address;
  wire          m8_read;
  wire          m8_write;
  wire  [3:0]   m8_burstcount;
  wire  [511:0] m8_writedata;
  wire  [63:0]  m8_byteenable;

  ofs_plat_avalon_mem_burst_split_stage dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_burstcount(s_burstcount),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .s_response(s_response),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_response(m_response)
  );

  ofs_plat_avalon_mem_burst_split_stage #(.ADDR_WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address[7:0]), .s_read(s_read), .s_write(s_write), .s_burstcount(s_burstcount),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s8_waitrequest),
    .s_readdata(s8_readdata), .s_readdatavalid(s8_readdatavalid), .s_response(s8_response),
    .m_address(m8_address), .m_read(m8_read), .m_write(m8_write), .m_burstcount(m8_burstcount),
    .m_writedata(m8_writedata), .m_byteenable(m8_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_response(m_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          tag;
    logic [26:0] addr;
    logic [3:0]  bc;
    logic [63:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          pending = 0;
  int          rsp_beats = 0;
  int          wait_mode = 0;   // 0: never stall, 1: random, 2: always stall
  logic [63:0] rsp_seq = 64'h1000;
  logic [63:0] exp_rdata = '0;
  bit          exp_rv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit wr, input bit tag, input logic [26:0] a, input logic [3:0] b,
                      input logic [63:0] d);
    exp_t e;
    e.wr = wr; e.tag = tag; e.addr = a; e.bc = b; e.data = d;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    #2;
    m_waitrequest = (wait_mode == 2) || (wait_mode == 1 && $urandom_range(0, 1) == 1);
  end

  // Monitor: checks accepted sink commands and the read response pass-through
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (m_read || m_write) && !m_waitrequest) begin
      if (sbq.size() == 0) begin
        chk("unexpected_cmd", {36'b0, m_address, m_burstcount}, 64'h0);
      end else begin
        e = sbq.pop_front();
        chk("cmd_kind", 64'(m_write), 64'(e.wr));
        if (e.tag) begin
          chk("cmd_addr", 64'(m_address), 64'(e.addr));
          chk("cmd_bc", 64'(m_burstcount), 64'(e.bc));
        end
        if (e.wr) begin
          chk("wr_data", m_writedata[63:0], e.data);
          chk("wr_be", m_byteenable, ~e.data);
        end
      end
      if (m_read) pending += int'(m_burstcount);
    end
    if (exp_rv || s_readdatavalid) begin
      chk("rsp_valid", 64'(s_readdatavalid), 64'(exp_rv));
      chk("rsp_data", s_readdata[511:448], exp_rdata);
      chk("rsp_code", 64'(s_response), 64'(exp_rdata[1:0]));
      if (s_readdatavalid) rsp_beats++;
    end
    if (!reset_n) pending = 0;
    if (pending > 0) begin
      m_readdata      = {8{rsp_seq}};
      m_response      = rsp_seq[1:0];
      m_readdatavalid = 1'b1;
      exp_rdata       = rsp_seq;
      exp_rv          = 1'b1;
      rsp_seq         = rsp_seq + 64'd1;
      pending--;
    end else begin
      m_readdatavalid = 1'b0;
      exp_rv          = 1'b0;
    end
  end

  task automatic do_read(input logic [26:0] a, input logic [6:0] bc, input int exp_stalls);
    int stalls = 0;
    s_address = a; s_burstcount = bc; s_read = 1'b1;
    forever begin
      @(negedge clk);
      if (!s_waitrequest) break;
      stalls++;
      if (stalls > 200) begin
        chk("rd_accept_timeout", 64'(stalls), 64'h0);
        break;
      end
      @(posedge clk); #1;
    end
    if (exp_stalls >= 0) chk("rd_stalls", 64'(stalls), 64'(exp_stalls));
    @(posedge clk); #1;
    s_read = 1'b0;
  endtask

  task automatic do_write(input logic [26:0] a, input logic [6:0] bc, input logic [63:0] base);
    for (int i = 0; i < int'(bc); i++) begin
      int cyc = 0;
      s_write = 1'b1; s_address = a; s_burstcount = bc;
      s_writedata  = {8{base + 64'(i)}};
      s_byteenable = ~(base + 64'(i));
      forever begin
        @(negedge clk);
        if (!s_waitrequest) break;
        cyc++;
        if (cyc > 100) begin
          chk("wr_accept_timeout", 64'(cyc), 64'h0);
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    s_write = 1'b0;
  endtask

  initial begin
    int rsp0;
    int cyc;
    #2;
    chk("rst_m_read", 64'(m_read), 64'h0);
    chk("rst_m_write", 64'(m_write), 64'h0);
    chk("rst_rd_offset", 64'(dut.r_rd_offset), 64'h0);
    chk("rst_wr_in_burst", 64'(dut.r_wr_in_burst), 64'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // 20-beat read split into 8+8+4
    push(0, 1, 27'h100, 4'd8, 0);
    push(0, 1, 27'h108, 4'd8, 0);
    push(0, 1, 27'h110, 4'd4, 0);
    rsp0 = rsp_beats;
    do_read(27'h100, 7'd20, 2);
    cyc = 0;
    while (rsp_beats - rsp0 < 20 && cyc < 100) begin @(posedge clk); cyc++; end
    repeat (3) @(posedge clk);
    #1;
    chk("rsp_beat_total", 64'(rsp_beats - rsp0), 64'd20);

    // Exactly SINK_MAX and single-beat reads, back to back
    push(0, 1, 27'h500, 4'd8, 0);
    push(0, 1, 27'h600, 4'd1, 0);
    do_read(27'h500, 7'd8, 0);
    do_read(27'h600, 7'd1, 0);

    // 12-beat write under random backpressure, then a short write
    wait_mode = 1;
    for (int i = 0; i < 12; i++)
      push(1, (i % 8) == 0, 27'h40 + 27'(i), (12 - i > 8) ? 4'd8 : 4'(12 - i), 64'hA000 + 64'(i));
    push(1, 1, 27'h80, 4'd3, 64'hB000);
    push(1, 0, 27'h0, 4'd0, 64'hB001);
    push(1, 0, 27'h0, 4'd0, 64'hB002);
    do_write(27'h40, 7'd12, 64'hA000);
    do_write(27'h80, 7'd3, 64'hB000);
    @(posedge clk); #1;
    wait_mode = 0;

    // Second piece held off for 5 cycles
    push(0, 1, 27'h200, 4'd8, 0);
    push(0, 1, 27'h208, 4'd8, 0);
    @(posedge clk); #1;
    s_address = 27'h200; s_burstcount = 7'd16; s_read = 1'b1;
    @(negedge clk);
    chk("stall_first_wreq", 64'(s_waitrequest), 64'h1);
    @(posedge clk); #1;
    wait_mode = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_addr", 64'(m_address), 64'h208);
      chk("stall_bc", 64'(m_burstcount), 64'h8);
      chk("stall_offset", 64'(dut.r_rd_offset), 64'h8);
      if (i < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    wait_mode = 0;
    @(negedge clk);
    chk("stall_release_wreq", 64'(s_waitrequest), 64'h0);
    @(posedge clk); #1;
    s_read = 1'b0;

    // Reset in the middle of a split read
    push(0, 1, 27'h400, 4'd8, 0);
    s_address = 27'h400; s_burstcount = 7'd20; s_read = 1'b1;
    @(posedge clk); #1;
    chk("mid_rd_state", 64'(dut.r_rd_state), 64'h1);
    s_read = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rd_state", 64'(dut.r_rd_state), 64'h0);
    chk("rst_rd_offset2", 64'(dut.r_rd_offset), 64'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a write burst
    push(1, 1, 27'h300, 4'd8, 64'h3000);
    push(1, 0, 27'h0, 4'd0, 64'h3001);
    push(1, 0, 27'h0, 4'd0, 64'h3002);
    s_write = 1'b1; s_address = 27'h300; s_burstcount = 7'd12;
    for (int i = 0; i < 3; i++) begin
      s_writedata  = {8{64'h3000 + 64'(i)}};
      s_byteenable = ~(64'h3000 + 64'(i));
      @(posedge clk); #1;
    end
    s_write = 1'b0;
    chk("mid_wr_in_burst", 64'(dut.r_wr_in_burst), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wr_in_burst2", 64'(dut.r_wr_in_burst), 64'h0);
    chk("rst_rd_state2", 64'(dut.r_rd_state), 64'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    push(0, 1, 27'h700, 4'd8, 0);
    push(0, 1, 27'h708, 4'd8, 0);
    do_read(27'h700, 7'd16, 1);

    // Address wrap on the 8-bit instance
    push(0, 1, 27'h0FC, 4'd8, 0);
    push(0, 1, 27'h104, 4'd8, 0);
    s_address = 27'h0FC; s_burstcount = 7'd16; s_read = 1'b1;
    @(negedge clk);
    chk("wrap_addr0", 64'(m8_address), 64'hFC);
    chk("wrap_bc0", 64'(m8_burstcount), 64'h8);
    chk("wrap_wreq0", 64'(s8_waitrequest), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_addr1", 64'(m8_address), 64'h04);
    chk("wrap_bc1", 64'(m8_burstcount), 64'h8);
    chk("wrap_wreq1", 64'(s8_waitrequest), 64'h0);
    @(posedge clk); #1;
    s_read = 1'b0;

    cyc = 0;
    while ((sbq.size() != 0 || pending != 0) && cyc < 200) begin @(posedge clk); cyc++; end
    repeat (3) @(posedge clk);
    chk("sb_leftover", 64'(sbq.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
